// File: rtl/arbitro_pkg.sv
// Shared constants and helpers for the N-channel arbiter: mode and FSM encodings
// plus extraction of the destination field from a word.
package arbitro_pkg;

    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Widest word dest_of accepts; callers zero-extend narrower words.
    localparam int MAX_WORD = 64;

    function automatic logic [3:0] dest_of(input logic [MAX_WORD-1:0] word,
                                           input int word_size,
                                           input int dest_w);
        logic [MAX_WORD-1:0] sh;
        sh = word >> (word_size - dest_w);
        return sh[3:0] & 4'((1 << dest_w) - 1);
    endfunction

endpackage

// File: rtl/arbitro_rr_n_pick.sv
// Rotating priority encoder: grants the first set request at or after start,
// wrapping modulo NUM_CH.
module rot_prio_pick
    import arbitro_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEST_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [DEST_W-1:0] start,
    output logic [NUM_CH-1:0] grant,
    output logic              valid
);

    logic [DEST_W-1:0] idx;

    // NUM_CH is a power of two, so the DEST_W-bit add wraps for free.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = start + DEST_W'(k);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_n.sv
// Drains NUM_CH input FIFOs into NUM_CH output FIFOs, routing by the top address
// bits, with strict-priority or burst-limited round-robin grant policy.
module arbitro_rr_n
    import arbitro_pkg::*;
#(
    parameter int WORD_SIZE = 12,
    parameter int NUM_CH    = 4,
    parameter int DEST_W    = $clog2(NUM_CH),
    parameter int BURST     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arb_mode,
    input  logic [NUM_CH-1:0]           fifos_empty,
    input  logic [NUM_CH-1:0]           fifos_almost_full,
    input  logic [NUM_CH*WORD_SIZE-1:0] fifo_data_in,
    output logic [NUM_CH-1:0]           fifos_pop,
    output logic [NUM_CH-1:0]           fifos_push,
    output logic [WORD_SIZE-1:0]        fifo_data_out,
    output logic [DEST_W-1:0]           grant_ch,
    output logic                        busy
);

    logic [DEST_W-1:0]    dest [NUM_CH];
    logic [NUM_CH-1:0]    elig;
    logic [0:0]           state, state_nx;
    logic [DEST_W-1:0]    ptr, ptr_nx, owner, owner_nx;
    logic [3:0]           cnt, cnt_nx;
    logic [DEST_W-1:0]    start;
    logic [NUM_CH-1:0]    pick_oh, pop_oh;
    logic                 pick_vld, keep;
    logic [DEST_W-1:0]    pick_idx, pop_idx;
    logic [NUM_CH-1:0]    push_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [DEST_W-1:0]    grant_q;
    logic                 busy_q;

    // A channel is eligible only if its word's destination can accept it this cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dest[i] = DEST_W'(dest_of(MAX_WORD'(fifo_data_in[i*WORD_SIZE +: WORD_SIZE]),
                                      WORD_SIZE, DEST_W));
            elig[i] = !fifos_empty[i] && !fifos_almost_full[dest[i]];
        end
    end

    assign keep = (arb_mode == MODE_RR) && (state == ST_OWN) && elig[owner]
                  && (cnt < 4'(BURST));

    // Searching from owner+1 leaves the owner last, so it wins only when alone.
    always_comb begin
        if (arb_mode == MODE_STRICT) start = '0;
        else if (state == ST_OWN)    start = owner + DEST_W'(1);
        else                         start = ptr;
    end

    rot_prio_pick #(.NUM_CH(NUM_CH), .DEST_W(DEST_W)) u_pick (
        .req   (elig),
        .start (start),
        .grant (pick_oh),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (pick_oh[i]) pick_idx = DEST_W'(i);
    end

    always_comb begin
        pop_oh   = '0;
        pop_idx  = pick_idx;
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        cnt_nx   = cnt;
        if (arb_mode == MODE_STRICT) begin
            if (pick_vld) pop_oh = pick_oh;
            state_nx = ST_IDLE;
        end else if (keep) begin
            pop_oh  = NUM_CH'(1) << owner;
            pop_idx = owner;
            cnt_nx  = cnt + 4'd1;
        end else begin
            if (state == ST_OWN) ptr_nx = owner + DEST_W'(1);
            if (pick_vld) begin
                pop_oh   = pick_oh;
                owner_nx = pick_idx;
                cnt_nx   = 4'd1;
                state_nx = ST_OWN;
            end else begin
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        end
    end

    assign fifos_pop = reset ? '0 : pop_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            push_q  <= '0;
            data_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            owner  <= owner_nx;
            cnt    <= cnt_nx;
            busy_q <= |pop_oh;
            push_q <= (|pop_oh) ? (NUM_CH'(1) << dest[pop_idx]) : '0;
            if (|pop_oh) begin
                data_q  <= fifo_data_in[pop_idx*WORD_SIZE +: WORD_SIZE];
                grant_q <= pop_idx;
            end
        end
    end

    // A word popped just before reset is never delivered to the output FIFO.
    assign fifos_push    = push_q & {NUM_CH{~reset}};
    assign busy          = busy_q & ~reset;
    assign fifo_data_out = data_q;
    assign grant_ch      = grant_q;

endmodule

// File: tb/tb_arbitro_rr_n.sv
// Scoreboard bench for arbitro_rr_n: directed vectors enqueue expected pushes,
// a negedge monitor pops and compares them against the DUT output.
module tb_arbitro_rr_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_mode;
    logic [3:0]  fifos_empty;
    logic [3:0]  fifos_almost_full;
    logic [47:0] fifo_data_in;
    logic [3:0]  fifos_pop;
    logic [3:0]  fifos_push;
    logic [11:0] fifo_data_out;
    logic [1:0]  grant_ch;
    logic        busy;

    typedef struct {
        logic [3:0]  push;
        logic [11:0] data;
        logic [1:0]  gr;
    } exp_t;

    exp_t q[$];
    int   n_tot  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    arbitro_rr_n #(.WORD_SIZE(12), .NUM_CH(4), .BURST(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .arb_mode          (arb_mode),
        .fifos_empty       (fifos_empty),
        .fifos_almost_full (fifos_almost_full),
        .fifo_data_in      (fifo_data_in),
        .fifos_pop         (fifos_pop),
        .fifos_push        (fifos_push),
        .fifo_data_out     (fifo_data_out),
        .grant_ch          (grant_ch),
        .busy              (busy)
    );

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Check this cycle's pop, queue the push expected next cycle, advance one clock.
    task automatic step(input logic [3:0] ep, input logic [3:0] epush,
                        input logic [11:0] ed, input logic [1:0] eg, input string nm);
        exp_t e;
        #2;
        chk(32'(fifos_pop), 32'(ep), nm);
        if (ep != 4'b0000) begin
            e.push = epush;
            e.data = ed;
            e.gr   = eg;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fifos_push != 4'b0000) begin
            if (q.size() == 0) begin
                chk(32'(fifos_push), 32'h0, "unexpected_push");
            end else begin
                e = q.pop_front();
                chk(32'(fifos_push), 32'(e.push), "push");
                chk(32'(fifo_data_out), 32'(e.data), "data_out");
                chk(32'(grant_ch), 32'(e.gr), "grant_ch");
                chk(32'(busy), 32'h1, "busy");
            end
        end
    end

    initial begin
        logic [11:0] ha [4];
        logic [11:0] hb [4];
        int rr_ch [9];
        int af_ch [7];
        ha = '{12'h34C, 12'h6CF, 12'hB4D, 12'hF0F};
        hb = '{12'h34C, 12'h6CF, 12'h24D, 12'h30F};
        rr_ch = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        af_ch = '{0, 2, 2, 3, 3, 0, 0};

        reset             = 1'b1;
        arb_mode          = 1'b0;
        fifos_empty       = 4'b0000;
        fifos_almost_full = 4'b0000;
        fifo_data_in      = {ha[3], ha[2], ha[1], ha[0]};

        @(posedge clk); #1;
        chk(32'(fifos_push), 32'h0, "rst_push");
        chk(32'(fifo_data_out), 32'h0, "rst_data_out");
        chk(32'(grant_ch), 32'h0, "rst_grant");
        chk(32'(busy), 32'h0, "rst_busy");
        chk(32'(fifos_pop), 32'h0, "rst_pop1");
        @(posedge clk); #1;
        chk(32'(fifos_pop), 32'h0, "rst_pop2");
        reset = 1'b0;

        // Strict priority: channel 0 always wins.
        for (int i = 0; i < 3; i++) step(4'b0001, 4'b0001, 12'h34C, 2'd0, "strict_pop");

        // Round-robin, burst of two per channel; heads A route channel i to dest i.
        arb_mode = 1'b1;
        for (int i = 0; i < 9; i++)
            step(4'(1 << rr_ch[i]), 4'(1 << rr_ch[i]), ha[rr_ch[i]], 2'(rr_ch[i]), "rr_pop");

        // Dest 1 almost full: channel 1 is skipped, the rest (all dest 0) rotate.
        fifo_data_in      = {hb[3], hb[2], hb[1], hb[0]};
        fifos_almost_full = 4'b0010;
        for (int i = 0; i < 7; i++)
            step(4'(1 << af_ch[i]), 4'b0001, hb[af_ch[i]], 2'(af_ch[i]), "af_pop");
        fifos_almost_full = 4'b0000;
        step(4'b0010, 4'b0010, 12'h6CF, 2'd1, "af_clear_pop");

        // All empty: nothing popped, nothing pushed, FSM idles with ptr at 2.
        fifos_empty = 4'b1111;
        step(4'b0000, 4'b0000, 12'h000, 2'd0, "empty_pop");
        chk(32'(fifos_push), 32'h0, "empty_no_push");
        fifos_empty = 4'b0110;
        step(4'b1000, 4'b0001, 12'h30F, 2'd3, "idle_resume_pop");

        // Pop of F0F, then reset: the in-flight word must never be pushed.
        fifo_data_in = {ha[3], ha[2], ha[1], ha[0]};
        fifos_empty  = 4'b0111;
        #2;
        chk(32'(fifos_pop), 32'h8, "pop_f0f");
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk(32'(fifos_push), 32'h0, "drop_push");
        chk(32'(fifos_pop), 32'h0, "drop_pop");
        @(posedge clk); #1;
        chk(32'(fifos_push), 32'h0, "rst2_push");
        chk(32'(fifo_data_out), 32'h0, "rst2_data_out");
        chk(32'(grant_ch), 32'h0, "rst2_grant");
        chk(32'(busy), 32'h0, "rst2_busy");

        @(posedge clk); #6;
        chk(32'(q.size()), 32'h0, "scoreboard_drained");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_n.md
Name: arbitro_rr_n

Overview:
- Parametrised successor to the 4-channel arbiter. Drains NUM_CH input FIFOs into NUM_CH output FIFOs.
- The destination of each word comes from its top address bits.
- Supports two grant policies, selected at runtime: strict priority or burst-limited round-robin.
- Applies per-destination back-pressure instead of a global stall, and registers data, push and status outputs.
- Sits between the input FIFO bank and the output FIFO bank of the data path.

Parameters:
- WORD_SIZE, 12, word width including the destination field.
- NUM_CH, 4, number of input and output channels; power of two, 2..16.
- DEST_W, $clog2(NUM_CH), destination field width, taken from bits [WORD_SIZE-1 -: DEST_W].
- BURST, 2, maximum consecutive pops granted to one channel in round-robin mode; 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- arb_mode  in  1  0 = strict priority (channel 0 highest), 1 = round-robin with burst limit.
- fifos_empty  in  NUM_CH  empty flags of the input FIFOs.
- fifos_almost_full  in  NUM_CH  almost-full flags of the output FIFOs.
- fifo_data_in  in  NUM_CH*WORD_SIZE  show-ahead head words; channel i at [i*WORD_SIZE +: WORD_SIZE].
- fifos_pop  out  NUM_CH  one-hot or zero pop to the input FIFOs; combinational from the registered grant state and current inputs.
- fifos_push  out  NUM_CH  one-hot or zero push to the output FIFOs; registered.
- fifo_data_out  out  WORD_SIZE  word being pushed; registered.
- grant_ch  out  DEST_W  channel popped in the previous cycle; registered.
- busy  out  1  registered; 1 when a push was issued this cycle.

Behaviour:
- Reset values: fifos_push = 0, fifo_data_out = 0, grant_ch = 0, busy = 0, FSM in IDLE, rr pointer = 0, burst counter = 0.
- fifos_pop is 0 while reset is high.
- Eligibility: channel i is eligible when !fifos_empty[i] and !fifos_almost_full[dest(head_i)].
- Only eligible channels may be popped. At most one pop per cycle.
- Latency: a pop on channel i in cycle t produces fifos_push[dest] = 1, with fifo_data_out equal to that head word, in cycle t+1. Push pulses exactly one cycle.
- The word is forwarded unmodified.
- Output FIFOs must assert almost_full with at least 1 free slot, because one word is always in flight.
- Strict mode: each cycle, pop the lowest-index eligible channel. No state is kept beyond the output register.
- Round-robin mode uses an FSM with two states, IDLE and OWN.
  - IDLE: pick the first eligible channel at or after ptr, wrapping modulo NUM_CH. Pop it, set owner to that channel, set cnt = 1, go to OWN. If none is eligible, stay in IDLE.
  - OWN, owner eligible and cnt < BURST: pop owner, cnt++.
  - OWN, owner not eligible or cnt == BURST: set ptr = owner+1 (mod NUM_CH). Re-arbitrate in the same cycle from the new ptr, excluding the owner unless it is the only eligible channel. If a channel is popped, it becomes owner with cnt = 1; otherwise go to IDLE.
- Mode change: a change of arb_mode takes effect in the next cycle. Switching to strict forces IDLE; ptr is retained.
- All input FIFOs empty: no pop and no push; FSM returns to IDLE.
- Destination almost full: only words bound for that destination are held. Other channels continue; there is no head-of-line stall across channels.
- Simultaneous almost_full rise and pop: the pop uses the same-cycle flag value, so the word is not popped.
- Reset mid-operation: an in-flight word (popped in the previous cycle) is dropped. Push is 0 on the cycle after reset is sampled high.
- Width rules: cnt is 4 bits, and ptr and owner are DEST_W bits. Wrap is modulo NUM_CH with no overflow.

Decomposition:
- Package arbitro_pkg holds:
  - MODE_STRICT = 1'b0 and MODE_RR = 1'b1;
  - FSM state encoding ST_IDLE / ST_OWN;
  - a dest_of(word) function parameterised by WORD_SIZE and DEST_W.
- Sub-module rot_prio_pick: a rotating priority encoder. Inputs are NUM_CH req bits and a DEST_W start index. Outputs are a one-hot grant and a valid flag.
  - Strict mode uses start = 0.
  - Round-robin uses start = ptr or owner+1.

Test Plan (NUM_CH=4, WORD_SIZE=12, BURST=2; dest = bits[11:10]):
- Reset held 2 cycles with inputs active -> pop = 0, push = 0, data_out = 0. First pop is in the cycle after reset falls.
- Strict mode, all channels non-empty, heads 12'h34C/12'h6CF/12'hB4D/12'hF0F, no almost_full -> pop = 0001 every cycle. One cycle later: push = 0001, data_out = 12'h34C.
- Round-robin mode, all channels non-empty -> pop sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001. Each push follows one cycle later.
- Round-robin mode, almost_full = 0010, channel 1 head 12'h6CF (dest 1), other heads dest 0 -> channel 1 is never popped and the others rotate. Clearing almost_full makes channel 1 eligible at its next turn.
- fifos_empty = 1111 in cycle t -> pop = 0 in t, push = 0 in t+1. FSM is in IDLE, and the next non-empty channel at or after ptr is popped first.
- Reset asserted the cycle after a pop of 12'hF0F -> no push of 12'hF0F occurs, and all outputs are 0.
